adc_scan_sequencer: RTL and testbench

Hardware scan sequencer between the CPU-facing ADC register block and the SAR ADC conversion core. Walks an enabled-channel mask in ascending order and issues one conversion per channel, either once per software start or on every tick of an internal sample-rate timer. Results are tagged with their channel and buffered in an 8-entry FIFO. Software disable aborts any conversion in flight and returns the block to idle.

---
 rtl/adc_seq_pkg.sv | 36 +++
 rtl/adc_seq_fifo.sv | 51 +++++
 rtl/adc_scan_sequencer.sv | 184 ++++++++++++++++++
 tb/tb_adc_scan_sequencer.sv | 298 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/adc_seq_pkg.sv
// adc_seq_pkg: shared types and constants for the ADC scan sequencer.
// Holds FSM encoding, FIFO sizing, channel count and rd_data field map.
package adc_seq_pkg;

   typedef enum logic [2:0] {
      S_IDLE,
      S_WAIT_TICK,
      S_ISSUE,
      S_CONV,
      S_ABORT
   } state_t;

   localparam int FIFO_DEPTH = 8;
   localparam int PTR_W      = 3;
   localparam int LVL_W      = 4;
   localparam int NUM_CH     = 4;
   localparam int CH_W       = 2;
   localparam int RD_W       = 16;
   localparam int DATA_LSB   = 0;
   localparam int CHAN_LSB   = 12;

   function automatic logic [CH_W-1:0] lowest_ch(
      input logic [NUM_CH-1:0] m
   );
      lowest_ch = '0;
      for (int i = NUM_CH - 1; i >= 0; i--)
         if (m[i]) lowest_ch = CH_W'(i);
   endfunction

   function automatic logic [NUM_CH-1:0] ch_bit(
      input logic [CH_W-1:0] ch
   );
      ch_bit = NUM_CH'(1) << ch;
   endfunction

endpackage

// File: rtl/adc_seq_fifo.sv
// adc_seq_fifo: 8-deep show-ahead FIFO with level output.
// Ports: push/wr_data in, pop in, rd_data head, full, empty, level.
module adc_seq_fifo
   import adc_seq_pkg::*;
#(
   parameter int W = 14
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             push,
   input  logic [W-1:0]     wr_data,
   input  logic             pop,
   output logic [W-1:0]     rd_data,
   output logic             full,
   output logic             empty,
   output logic [LVL_W-1:0] level
);

   logic [W-1:0]     mem [FIFO_DEPTH];
   logic [PTR_W-1:0] wptr;
   logic [PTR_W-1:0] rptr;
   logic             do_push;
   logic             do_pop;

   assign empty   = (level == '0);
   assign full    = (level == LVL_W'(FIFO_DEPTH));
   assign do_pop  = pop && !empty;
   // a pop frees the slot, so push at full is legal
   assign do_push = push && (!full || do_pop);
   assign rd_data = mem[rptr];

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         wptr  <= '0;
         rptr  <= '0;
         level <= '0;
         for (int i = 0; i < FIFO_DEPTH; i++)
            mem[i] <= '0;
      end else begin
         if (do_push) begin
            mem[wptr] <= wr_data;
            wptr      <= wptr + PTR_W'(1);
         end
         if (do_pop)
            rptr <= rptr + PTR_W'(1);
         level <= level + LVL_W'(do_push)
                        - LVL_W'(do_pop);
      end
   end

endmodule

// File: rtl/adc_scan_sequencer.sv
// adc_scan_sequencer: walks a channel mask, drives the SAR core,
// buffers tagged results; cfg/start in, adc_* to core, rd_* out.
module adc_scan_sequencer
   import adc_seq_pkg::*;
#(
   parameter int DIV_W  = 16,
   parameter int DATA_W = 12
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              cfg_enable,
   input  logic              cfg_auto,
   input  logic [3:0]        cfg_chan_mask,
   input  logic [DIV_W-1:0]  cfg_div,
   input  logic              start,
   input  logic              clr_flags,
   output logic              adc_start,
   output logic [1:0]        adc_chan,
   output logic              adc_abort,
   input  logic              adc_busy,
   input  logic              adc_done,
   input  logic [DATA_W-1:0] adc_data,
   input  logic              rd_en,
   output logic              rd_valid,
   output logic [15:0]       rd_data,
   output logic [3:0]        fifo_level,
   output logic              busy,
   output logic              scan_done,
   output logic              overrun,
   output logic              late
);

   localparam int EW = CH_W + DATA_W;

   state_t           state;
   logic [3:0]       scan_mask;
   logic [DIV_W-1:0] tcnt;
   logic             t_run;
   logic             tick;
   logic             arm;
   logic             start_ok;
   logic [1:0]       ch_cfg;
   logic [1:0]       ch_scan;
   logic             push;
   logic [EW-1:0]    fifo_q;
   logic             fifo_full;
   logic             fifo_empty;

   assign ch_cfg   = lowest_ch(cfg_chan_mask);
   assign ch_scan  = lowest_ch(scan_mask);
   assign start_ok = start && cfg_enable
                  && (|cfg_chan_mask);
   assign arm      = (state == S_IDLE)
                  && start_ok && cfg_auto;
   assign t_run    = cfg_auto
                  && (state == S_WAIT_TICK
                   || state == S_ISSUE
                   || state == S_CONV);
   assign tick     = t_run && (tcnt == cfg_div);
   assign push     = (state == S_CONV)
                  && cfg_enable && adc_done;

   assign busy       = (state != S_IDLE);
   assign rd_valid   = !fifo_empty;

   always_comb begin
      rd_data = '0;
      rd_data[CHAN_LSB +: CH_W]   = fifo_q[DATA_W +: CH_W];
      rd_data[DATA_LSB +: DATA_W] = fifo_q[0 +: DATA_W];
   end

   adc_seq_fifo #(.W(EW)) u_fifo (
      .clk     (clk),
      .reset   (reset),
      .push    (push),
      .wr_data ({adc_chan, adc_data}),
      .pop     (rd_en),
      .rd_data (fifo_q),
      .full    (fifo_full),
      .empty   (fifo_empty),
      .level   (fifo_level)
   );

   always_ff @(posedge clk or posedge reset) begin
      if (reset)
         tcnt <= '0;
      else if (arm)
         tcnt <= '0;
      else if (t_run)
         tcnt <= tick ? '0 : tcnt + DIV_W'(1);
   end

   // set events take priority over a clear in the same cycle
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         overrun <= 1'b0;
         late    <= 1'b0;
      end else begin
         if (push && fifo_full && !rd_en)
            overrun <= 1'b1;
         else if (clr_flags)
            overrun <= 1'b0;
         if (tick && state != S_WAIT_TICK)
            late <= 1'b1;
         else if (clr_flags)
            late <= 1'b0;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state     <= S_IDLE;
         scan_mask <= '0;
         adc_start <= 1'b0;
         adc_chan  <= '0;
         adc_abort <= 1'b0;
         scan_done <= 1'b0;
      end else begin
         adc_start <= 1'b0;
         adc_abort <= 1'b0;
         scan_done <= 1'b0;
         unique case (state)
            S_IDLE: begin
               if (start_ok) begin
                  scan_mask <= cfg_chan_mask;
                  if (cfg_auto) begin
                     state <= S_WAIT_TICK;
                  end else if (!adc_busy) begin
                     // issue directly so the request
                     // follows start by one cycle
                     adc_start <= 1'b1;
                     adc_chan  <= ch_cfg;
                     scan_mask <= cfg_chan_mask
                                & ~ch_bit(ch_cfg);
                     state     <= S_CONV;
                  end else begin
                     state <= S_ISSUE;
                  end
               end
            end
            S_WAIT_TICK: begin
               if (!cfg_enable) begin
                  state <= S_IDLE;
               end else if (tick) begin
                  scan_mask <= cfg_chan_mask;
                  if (|cfg_chan_mask)
                     state <= S_ISSUE;
               end
            end
            S_ISSUE: begin
               if (!cfg_enable) begin
                  state <= S_IDLE;
               end else if (!adc_busy) begin
                  adc_start <= 1'b1;
                  adc_chan  <= ch_scan;
                  scan_mask <= scan_mask
                             & ~ch_bit(ch_scan);
                  state     <= S_CONV;
               end
            end
            S_CONV: begin
               if (!cfg_enable) begin
                  adc_abort <= 1'b1;
                  state     <= S_ABORT;
               end else if (adc_done) begin
                  if (|scan_mask) begin
                     state <= S_ISSUE;
                  end else begin
                     scan_done <= 1'b1;
                     state <= cfg_auto ? S_WAIT_TICK
                                       : S_IDLE;
                  end
               end
            end
            S_ABORT: begin
               if (!adc_busy)
                  state <= S_IDLE;
            end
            default: state <= S_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_adc_scan_sequencer.sv
// tb_adc_scan_sequencer: scoreboard bench for adc_scan_sequencer.
// Models the SAR core; expected FIFO entries are queued on adc_done.
module tb_adc_scan_sequencer;

   logic        clk = 1'b0;
   logic        reset;
   logic        cfg_enable;
   logic        cfg_auto;
   logic [3:0]  cfg_chan_mask;
   logic [15:0] cfg_div;
   logic        start;
   logic        clr_flags;
   logic        adc_start;
   logic [1:0]  adc_chan;
   logic        adc_abort;
   logic        adc_busy;
   logic        adc_done;
   logic [11:0] adc_data;
   logic        rd_en;
   logic        rd_valid;
   logic [15:0] rd_data;
   logic [3:0]  fifo_level;
   logic        busy;
   logic        scan_done;
   logic        overrun;
   logic        late;

   int          errs   = 0;
   int          checks = 0;
   int          cyc    = 0;
   logic [15:0] q[$];
   bit          exp_ovr = 1'b0;

   adc_scan_sequencer #(.DIV_W(16), .DATA_W(12)) dut (
      .clk           (clk),
      .reset         (reset),
      .cfg_enable    (cfg_enable),
      .cfg_auto      (cfg_auto),
      .cfg_chan_mask (cfg_chan_mask),
      .cfg_div       (cfg_div),
      .start         (start),
      .clr_flags     (clr_flags),
      .adc_start     (adc_start),
      .adc_chan      (adc_chan),
      .adc_abort     (adc_abort),
      .adc_busy      (adc_busy),
      .adc_done      (adc_done),
      .adc_data      (adc_data),
      .rd_en         (rd_en),
      .rd_valid      (rd_valid),
      .rd_data       (rd_data),
      .fifo_level    (fifo_level),
      .busy          (busy),
      .scan_done     (scan_done),
      .overrun       (overrun),
      .late          (late)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string tag,
                      input logic [31:0] act,
                      input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errs++;
         $display("FAIL %s act=0x%0h exp=0x%0h",
                  tag, act, exp);
      end
   endtask

   task automatic pulse_start();
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
   endtask

   task automatic pulse_clr();
      clr_flags = 1'b1;
      @(negedge clk);
      clr_flags = 1'b0;
   endtask

   // core model: wait for a request, convert for lat cycles,
   // return data; the expected entry is queued on adc_done
   task automatic convert(input logic [1:0]  ch,
                          input logic [11:0] d,
                          input int          lat,
                          input bit          pop,
                          output int         tcyc);
      int n;
      n = 0;
      while (adc_start !== 1'b1 && n < 400) begin
         @(negedge clk);
         n++;
      end
      tcyc = cyc;
      chk("adc_start_seen", adc_start, 1);
      if (adc_start !== 1'b1) return;
      chk("adc_chan", adc_chan, ch);
      adc_busy = 1'b1;
      @(negedge clk);
      chk("adc_start_1cyc", adc_start, 0);
      repeat (lat - 1) @(negedge clk);
      chk("adc_chan_hold", adc_chan, ch);
      adc_done = 1'b1;
      adc_data = d;
      adc_busy = 1'b0;
      if (pop && q.size() > 0) begin
         chk("rd_data_pop", rd_data, q[0]);
         rd_en = 1'b1;
         void'(q.pop_front());
      end
      if (q.size() < 8) q.push_back({2'b00, ch, d});
      else exp_ovr = 1'b1;
      @(negedge clk);
      adc_done = 1'b0;
      rd_en    = 1'b0;
   endtask

   task automatic drain();
      while (q.size() > 0) begin
         chk("rd_valid", rd_valid, 1);
         chk("rd_data", rd_data, q[0]);
         void'(q.pop_front());
         rd_en = 1'b1;
         @(negedge clk);
         rd_en = 1'b0;
      end
      chk("drain_empty", rd_valid, 0);
      chk("drain_level", fifo_level, 0);
   endtask

   task automatic stop_block();
      cfg_enable = 1'b0;
      @(negedge clk);
      chk("stop_busy", busy, 0);
      cfg_enable = 1'b1;
   endtask

   initial begin
      #300000;
      $display("FAIL watchdog act=running exp=finished");
      $fatal(1, "watchdog");
   end

   initial begin
      int t0;
      int tc;
      int n;
      reset = 1'b1;
      cfg_enable = 1'b0;
      cfg_auto = 1'b0;
      cfg_chan_mask = 4'b0000;
      cfg_div = 16'd0;
      start = 1'b0;
      clr_flags = 1'b0;
      adc_busy = 1'b0;
      adc_done = 1'b0;
      adc_data = 12'd0;
      rd_en = 1'b0;
      repeat (3) @(negedge clk);
      reset = 1'b0;
      @(negedge clk);
      chk("rst_outs",
          {adc_start, adc_chan, adc_abort, rd_valid,
           busy, scan_done, overrun, late}, 0);
      chk("rst_rd_data", rd_data, 0);
      chk("rst_level", fifo_level, 0);

      // ignored start: empty mask
      cfg_enable = 1'b1;
      pulse_start();
      chk("start_mask0", busy, 0);

      // single scan over channels 1 and 3
      cfg_chan_mask = 4'b1010;
      pulse_start();
      chk("single_t1_start", adc_start, 1);
      chk("single_busy", busy, 1);
      convert(2'd1, 12'd1543, 3, 1'b0, tc);
      chk("single_valid", rd_valid, 1);
      chk("single_level", fifo_level, 1);
      chk("single_no_sd", scan_done, 0);
      convert(2'd3, 12'd2654, 3, 1'b0, tc);
      chk("single_scan_done", scan_done, 1);
      @(negedge clk);
      chk("single_sd_1cyc", scan_done, 0);
      chk("single_idle", busy, 0);
      chk("single_q0", q[0], 16'h1607);
      chk("single_q1", q[1], 16'h3A5E);
      drain();

      // auto mode, period 100 cycles
      cfg_auto = 1'b1;
      cfg_chan_mask = 4'b0001;
      cfg_div = 16'd99;
      pulse_start();
      t0 = cyc;
      for (int i = 0; i < 5; i++) begin
         convert(2'd0, 12'd3129, 5, 1'b0, tc);
         chk("auto_period", tc - t0,
             (i == 0) ? 101 : 100);
         t0 = tc;
      end
      chk("auto_level", fifo_level, 5);
      chk("auto_late", late, 0);
      stop_block();
      chk("auto_q0", q[0], 16'h0C39);
      drain();

      // overrun: 9 results into 8 slots
      cfg_div = 16'd19;
      pulse_start();
      for (int i = 0; i < 9; i++)
         convert(2'd0, 12'(100 + i), 3, 1'b0, tc);
      chk("ovr_level", fifo_level, 8);
      chk("ovr_flag", overrun, exp_ovr);
      chk("ovr_flag_set", overrun, 1);
      pulse_clr();
      exp_ovr = 1'b0;
      chk("ovr_clr", overrun, 0);
      convert(2'd0, 12'd555, 3, 1'b1, tc);
      chk("ovr_pushpop", overrun, 0);
      chk("ovr_pushpop_lvl", fifo_level, 8);
      stop_block();
      drain();

      // late tick: short period, slow core
      cfg_div = 16'd3;
      pulse_start();
      convert(2'd0, 12'h7FF, 10, 1'b0, tc);
      chk("late_set", late, 1);
      stop_block();
      pulse_clr();
      chk("late_clr", late, 0);
      drain();

      // abort mid-conversion
      cfg_auto = 1'b0;
      cfg_chan_mask = 4'b0100;
      pulse_start();
      chk("abort_start", adc_start, 1);
      chk("abort_chan", adc_chan, 2);
      adc_busy = 1'b1;
      repeat (2) @(negedge clk);
      cfg_enable = 1'b0;
      adc_done = 1'b1;
      adc_data = 12'h123;
      @(negedge clk);
      adc_done = 1'b0;
      chk("abort_pulse", adc_abort, 1);
      chk("abort_busy", busy, 1);
      @(negedge clk);
      chk("abort_1cyc", adc_abort, 0);
      adc_done = 1'b1;
      @(negedge clk);
      adc_done = 1'b0;
      chk("abort_no_push", fifo_level, 0);
      adc_busy = 1'b0;
      @(negedge clk);
      chk("abort_idle", busy, 0);
      chk("abort_empty", rd_valid, 0);
      cfg_enable = 1'b1;

      // async reset mid-scan
      cfg_chan_mask = 4'b1111;
      pulse_start();
      convert(2'd0, 12'h0AA, 2, 1'b0, tc);
      n = 0;
      while (adc_start !== 1'b1 && n < 20) begin
         @(negedge clk);
         n++;
      end
      chk("rst2_start", adc_start, 1);
      adc_busy = 1'b1;
      #2;
      reset = 1'b1;
      #1;
      chk("rst2_outs",
          {adc_start, adc_chan, adc_abort, rd_valid,
           busy, scan_done, overrun, late}, 0);
      chk("rst2_rd_data", rd_data, 0);
      chk("rst2_level", fifo_level, 0);
      adc_busy = 1'b0;
      @(negedge clk);
      reset = 1'b0;
      q.delete();
      @(negedge clk);
      chk("rst2_idle", busy, 0);

      $display("Result: errors=%0d of %0d checks",
               errs, checks);
      $finish;
   end

endmodule
